// File: rtl/mem_datapath_pkg.sv
// Shared pipeline types for the memory stage: control words and the EX/MEM and MEM/WB registers.
// Consumers import control::* and regfile::*.
package control;

    typedef struct packed {
        logic       load_unsigned;
        logic [1:0] access_size;
    } mem_control_word;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } wb_control_word;

endpackage

package regfile;

    // Access size as encoded in funct3[1:0]
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] u_imm;
        logic        br_en;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_regfile;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] u_imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] mem_rdata;
        logic [3:0]  mem_byte_enable;
    } mem_wb_regfile;

endpackage

// File: rtl/mem_datapath_mask_gen.sv
// Byte-enable and write-data lane steering for the memory stage.
// The misalignment test is only built with MEM_MISALIGN_CHECK_EN; otherwise it reports aligned.
module mem_mask_gen
    import regfile::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] rs2,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        mbe        = 4'b1111;
        wdata      = rs2 << {offset, 3'b000};
        misaligned = 1'b0;
        // Shifted masks fall off the top of the 4-bit lane field when they straddle the word
        case (size)
            SIZE_BYTE: mbe = 4'b0001 << offset;
            SIZE_HALF: mbe = 4'b0011 << offset;
            default:   mbe = 4'b1111;
        endcase
`ifdef MEM_MISALIGN_CHECK_EN
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = offset[0];
            default:   misaligned = |offset;
        endcase
`endif
    end

endmodule

// File: rtl/mem_datapath.sv
// Memory stage: issues one data-bus transaction per load/store and stalls upstream until it completes.
// MEM_MISALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them on misalign_err.
module mem_datapath
    import regfile::*;
    import control::*;
(
    input  logic            clk,
    input  logic            rst,
    input  ex_mem_regfile   ex_in,
    input  mem_control_word mem_control,
    input  wb_control_word  wb_control,
    output logic            data_read,
    output logic            data_write,
    output logic [31:0]     data_addr,
    output logic [31:0]     data_wdata,
    output logic [3:0]      data_mbyte_enable,
    input  logic            data_resp,
    input  logic [31:0]     data_rdata,
    output mem_wb_regfile   reg_out,
    output mem_control_word wb_mem_control,
    output wb_control_word  wb_wb_control,
    output logic            stall_mem,
    output logic            misalign_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic        mem_op, misaligned, suppressed, issue, resp_busy;
    logic [3:0]  mbe;
    logic [31:0] wdata;

    mem_mask_gen u_mask_gen (
        .offset     (ex_in.alu_out[1:0]),
        .size       (ex_in.funct3[1:0]),
        .rs2        (ex_in.rs2_out),
        .mbe        (mbe),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_op     = ex_in.valid & (ex_in.mem_read | ex_in.mem_write);
        suppressed = mem_op & misaligned;
        issue      = (state == IDLE) & mem_op & ~suppressed;
        resp_busy  = (state == BUSY) & data_resp;
        stall_mem  = issue | ((state == BUSY) & ~data_resp);
        case (state)
            IDLE:    if (issue) state_next = BUSY;
            BUSY:    if (data_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_read         <= 1'b0;
            data_write        <= 1'b0;
            data_addr         <= '0;
            data_wdata        <= '0;
            data_mbyte_enable <= '0;
            reg_out           <= '0;
            wb_mem_control    <= '0;
            wb_wb_control     <= '0;
        end else begin
            // A read+write op is issued as a write
            if (issue) begin
                data_read         <= ex_in.mem_read & ~ex_in.mem_write;
                data_write        <= ex_in.mem_write;
                data_addr         <= {ex_in.alu_out[31:2], 2'b00};
                data_wdata        <= wdata;
                data_mbyte_enable <= mbe;
            end else if (resp_busy) begin
                data_read  <= 1'b0;
                data_write <= 1'b0;
            end
            if (stall_mem) begin
                reg_out.valid <= 1'b0;
            end else begin
                reg_out.valid           <= ex_in.valid & ~suppressed;
                reg_out.pc              <= ex_in.pc;
                reg_out.alu_out         <= ex_in.alu_out;
                reg_out.br_en           <= ex_in.br_en;
                reg_out.u_imm           <= ex_in.u_imm;
                reg_out.rd              <= ex_in.rd;
                reg_out.funct3          <= ex_in.funct3;
                reg_out.mem_rdata       <= resp_busy ? data_rdata : 32'h0;
                reg_out.mem_byte_enable <= mbe;
                wb_mem_control          <= mem_control;
                wb_wb_control           <= wb_control;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= (state == IDLE) & suppressed;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_datapath.sv
// Directed bench for mem_datapath: loads, stores, bubbles, reset mid-transaction, misaligned access.
module tb_mem_datapath;
    import regfile::*;
    import control::*;

    logic            clk = 1'b0;
    logic            rst;
    ex_mem_regfile   ex_in;
    mem_control_word mem_control;
    wb_control_word  wb_control;
    logic            data_read, data_write;
    logic [31:0]     data_addr, data_wdata;
    logic [3:0]      data_mbyte_enable;
    logic            data_resp;
    logic [31:0]     data_rdata;
    mem_wb_regfile   reg_out;
    mem_control_word wb_mem_control;
    wb_control_word  wb_wb_control;
    logic            stall_mem, misalign_err;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_datapath dut (
        .clk               (clk),
        .rst               (rst),
        .ex_in             (ex_in),
        .mem_control       (mem_control),
        .wb_control        (wb_control),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_mbyte_enable (data_mbyte_enable),
        .data_resp         (data_resp),
        .data_rdata        (data_rdata),
        .reg_out           (reg_out),
        .wb_mem_control    (wb_mem_control),
        .wb_wb_control     (wb_wb_control),
        .stall_mem         (stall_mem),
        .misalign_err      (misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_regfile mk(input logic [31:0] alu, input logic [31:0] rs2,
                                         input logic [2:0] f3, input logic rd_en,
                                         input logic wr_en, input logic [4:0] rd_idx);
        ex_mem_regfile e;
        e           = '0;
        e.valid     = 1'b1;
        e.pc        = 32'h0000_1000;
        e.alu_out   = alu;
        e.rs2_out   = rs2;
        e.u_imm     = 32'h0001_2000;
        e.funct3    = f3;
        e.rd        = rd_idx;
        e.mem_read  = rd_en;
        e.mem_write = wr_en;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        ex_in       = '0;
        mem_control = '0;
        wb_control  = '0;
        data_resp   = 1'b0;
        data_rdata  = '0;
        repeat (2) step();
        check("rst_valid", reg_out.valid, 0);
        check("rst_read", data_read, 0);
        check("rst_write", data_write, 0);
        check("rst_addr", data_addr, 0);
        check("rst_mbe", data_mbyte_enable, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_stall", stall_mem, 0);
        rst = 1'b0;

        // Non-memory op: no stall, appears on the next edge
        ex_in      = mk(32'h55, 32'h0, 3'b000, 1'b0, 1'b0, 5'd3);
        wb_control = 3'b101;
        #1 check("add_stall", stall_mem, 0);
        step();
        check("add_valid", reg_out.valid, 1);
        check("add_alu", reg_out.alu_out, 32'h55);
        check("add_rd", reg_out.rd, 3);
        check("add_wbctl", wb_wb_control, 3'b101);

        // lw 0x100 with response after three BUSY cycles
        ex_in     = mk(32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd7);
        stall_cnt = 0;
        #1 if (stall_mem) stall_cnt++;
        check("lw_issue_rd_early", data_read, 0);
        step();
        check("lw_read", data_read, 1);
        check("lw_addr", data_addr, 32'h100);
        check("lw_mbe", data_mbyte_enable, 4'b1111);
        check("lw_bubble", reg_out.valid, 0);
        for (int i = 0; i < 3; i++) begin
            if (stall_mem) stall_cnt++;
            step();
        end
        check("lw_read_held", data_read, 1);
        data_resp  = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        #1 check("lw_resp_stall", stall_mem, 0);
        check("lw_stall_cycles", stall_cnt, 4);
        step();
        data_resp = 1'b0;
        ex_in     = '0;
        check("lw_valid", reg_out.valid, 1);
        check("lw_rdata", reg_out.mem_rdata, 32'hDEAD_BEEF);
        check("lw_rd", reg_out.rd, 7);
        check("lw_rbe", reg_out.mem_byte_enable, 4'b1111);
        check("lw_read_clr", data_read, 0);

        // sb at 0x203
        ex_in = mk(32'h203, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 5'd0);
        step();
        check("sb_write", data_write, 1);
        check("sb_read", data_read, 0);
        check("sb_addr", data_addr, 32'h200);
        check("sb_mbe", data_mbyte_enable, 4'b1000);
        check("sb_wdata", data_wdata, 32'hAB00_0000);
        step();
        check("sb_write_held", data_write, 1);
        data_resp = 1'b1;
        step();
        data_resp = 1'b0;
        check("sb_write_clr", data_write, 0);

        // sh at 0x202, then lh at 0x202
        ex_in = mk(32'h202, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 5'd0);
        step();
        check("sh_mbe", data_mbyte_enable, 4'b1100);
        check("sh_wdata", data_wdata, 32'h1234_0000);
        data_resp = 1'b1;
        step();
        data_resp = 1'b0;
        ex_in     = mk(32'h202, 32'h0, 3'b001, 1'b1, 1'b0, 5'd9);
        step();
        check("lh_read", data_read, 1);
        data_resp  = 1'b1;
        data_rdata = 32'h5678_0000;
        step();
        data_resp = 1'b0;
        check("lh_rbe", reg_out.mem_byte_enable, 4'b1100);
        check("lh_valid", reg_out.valid, 1);
        check("lh_rdata", reg_out.mem_rdata, 32'h5678_0000);

        // lw with immediate response followed by an add
        ex_in = mk(32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10);
        step();
        data_resp  = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        #1 check("b2b_resp_stall", stall_mem, 0);
        check("b2b_bubble", reg_out.valid, 0);
        step();
        data_resp = 1'b0;
        check("b2b_lw_valid", reg_out.valid, 1);
        check("b2b_lw_rd", reg_out.rd, 10);
        check("b2b_lw_rdata", reg_out.mem_rdata, 32'hCAFE_F00D);
        ex_in = mk(32'h77, 32'h0, 3'b000, 1'b0, 1'b0, 5'd11);
        #1 check("b2b_add_stall", stall_mem, 0);
        step();
        check("b2b_add_valid", reg_out.valid, 1);
        check("b2b_add_rd", reg_out.rd, 11);
        check("b2b_add_alu", reg_out.alu_out, 32'h77);
        check("b2b_add_rdata", reg_out.mem_rdata, 0);

        // Reset while BUSY, then a stale response
        ex_in = mk(32'h300, 32'h0, 3'b010, 1'b1, 1'b0, 5'd12);
        step();
        check("rstb_read", data_read, 1);
        rst         = 1'b1;
        ex_in.valid = 1'b0;
        step();
        rst        = 1'b0;
        data_resp  = 1'b1;
        data_rdata = 32'h1111_1111;
        check("rstb_read_clr", data_read, 0);
        check("rstb_addr", data_addr, 0);
        check("rstb_valid", reg_out.valid, 0);
        #1 check("rstb_stale_stall", stall_mem, 0);
        step();
        data_resp = 1'b0;
        check("rstb_read_after", data_read, 0);
        check("rstb_valid_after", reg_out.valid, 0);
        check("rstb_rdata_after", reg_out.mem_rdata, 0);

        // lw at 0x102 (misaligned word)
        ex_in = mk(32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 5'd13);
`ifdef MEM_MISALIGN_CHECK_EN
        #1 check("mis_stall", stall_mem, 0);
        step();
        ex_in.valid = 1'b0;
        check("mis_read", data_read, 0);
        check("mis_err", misalign_err, 1);
        check("mis_valid", reg_out.valid, 0);
        step();
        check("mis_err_pulse", misalign_err, 0);
`else
        #1 check("unal_stall", stall_mem, 1);
        step();
        check("unal_read", data_read, 1);
        check("unal_addr", data_addr, 32'h100);
        check("unal_err", misalign_err, 0);
        data_resp = 1'b1;
        step();
        data_resp   = 1'b0;
        ex_in.valid = 1'b0;
        check("unal_valid", reg_out.valid, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_datapath.md
MEM_DATAPATH -- requirements
Module: mem_datapath

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL take ex_in input ex_mem_regfile: valid, pc, alu_out, rs2_out, u_imm, br_en, funct3, rd, mem_read, mem_write.
REQ-003 SHALL take mem_control input mem_control_word and wb_control input wb_control_word, passed through to the WB stage.
REQ-004 SHALL drive data_read output 1, data_write output 1, data_addr output 32 (word-aligned), data_wdata output 32, data_mbyte_enable output 4.
REQ-005 SHALL take data_resp input 1 (one-cycle completion) and data_rdata input 32.
REQ-006 SHALL drive reg_out output mem_wb_regfile, which carries alu_out, br_en, u_imm, pc, rd, funct3, mem_rdata, mem_byte_enable and valid.
REQ-007 SHALL drive stall_mem output 1, which holds all upstream stages.
REQ-008 SHALL drive misalign_err output 1.

Function
REQ-009 SHALL implement the FSM IDLE/BUSY with the following transitions:
- IDLE->BUSY when ex_in.valid and (mem_read|mem_write) and the access is not suppressed.
- BUSY->IDLE on data_resp.
REQ-010 SHALL register data_read, data_write, data_addr, data_wdata and data_mbyte_enable on the IDLE->BUSY edge, hold them stable throughout BUSY, and clear read/write on the cycle after data_resp.
REQ-011 SHALL compute stall_mem = (IDLE & valid memory op & not suppressed) | (BUSY & !data_resp), combinationally.
REQ-012 SHALL compute data_addr = {alu_out[31:2], 2'b00}.
REQ-013 SHALL compute mbe as follows:
- funct3[1:0]=00 (byte): 4'b0001<<alu_out[1:0].
- 01 (half): 4'b0011<<alu_out[1:0].
- 10 (word): 4'b1111.
- Result truncated to 4 bits.
REQ-014 SHALL compute data_wdata = rs2_out << (8*alu_out[1:0]).
REQ-015 SHALL latch data_rdata into reg_out.mem_rdata on the data_resp cycle; a load therefore reaches reg_out one cycle after data_resp.
REQ-016 SHALL update reg_out every cycle stall_mem=0, copying ex_in fields plus the computed mbe into mem_byte_enable.
REQ-017 SHALL load reg_out.valid=0 (bubble) on every cycle stall_mem=1.
REQ-018 SHALL give non-memory instructions zero added latency: reg_out updates on the next edge.
REQ-019 SHALL give a memory op a minimum latency of 2 cycles (issue, then response) when data_resp arrives on the first BUSY cycle.
REQ-020 SHALL ignore data_resp in IDLE (spurious).
REQ-021 SHALL treat mem_read and mem_write both set as a write.

Reset
REQ-022 SHALL, on rst, force the following regardless of state, including mid-BUSY:
- state=IDLE.
- data_read=0, data_write=0, data_addr=0, data_wdata=0, data_mbyte_enable=0.
- reg_out all fields 0, valid=0.
- misalign_err=0.
REQ-023 SHALL abandon an outstanding transaction on reset; a later data_resp is ignored.

Configuration
REQ-024 SHALL use macro MEM_MISALIGN_CHECK_EN to compile the misalignment check in or out.
REQ-025 SHALL, with MEM_MISALIGN_CHECK_EN defined:
- Treat half with alu_out[0]=1, or word with alu_out[1:0]!=0, as suppressed: no request, no stall.
- Pulse misalign_err for one cycle.
- Forward reg_out with valid=0.
REQ-026 SHALL, without MEM_MISALIGN_CHECK_EN: issue all accesses using the truncated mask and tie misalign_err to 0.

Structure
REQ-027 SHALL define ex_mem_regfile and mem_wb_regfile in package regfile, and the control words in package control.
REQ-028 SHALL declare the IDLE/BUSY enum locally.
REQ-029 SHALL place mbe/wdata generation and the misalignment test in combinational sub-module mem_mask_gen.

Verification
REQ-030 SHALL cover: lw, alu_out=0x100, resp after 3 BUSY cycles, rdata=0xDEADBEEF -> data_addr=0x100, mbe=1111, stall high 4 cycles, reg_out.mem_rdata=0xDEADBEEF, valid=1.
REQ-031 SHALL cover: sb, alu_out=0x203, rs2=0x000000AB -> mbe=1000, wdata=0xAB000000, data_write held until resp.
REQ-032 SHALL cover: sh, alu_out=0x202, rs2=0x1234 -> mbe=1100, wdata=0x12340000; lh at 0x202 -> reg_out.mem_byte_enable=1100.
REQ-033 SHALL cover: add back-to-back after lw with immediate resp -> one bubble (valid=0) then add result, no lost instruction.
REQ-034 SHALL cover: rst asserted mid-BUSY, then data_resp next cycle -> state IDLE, reads/writes 0, reg_out.valid=0, resp ignored.
REQ-035 SHALL cover, with MEM_MISALIGN_CHECK_EN: lw at 0x102 -> no data_read, misalign_err=1 one cycle, reg_out.valid=0.
